sp_weight_compressor: RTL and testbench

Upstream feeder of the sparse threadgroup.
- Accepts dense int8 weight rows, 8 weights per beat (two groups of 4).
- Enforces 2:4 structured sparsity by magnitude and emits per beat:
  - 4 compressed weights on `weight_group`, directly consumable as `weight_group0`/`weight_group1`;
  - the 8-bit select index on `weight_idx`, consumed by the 8-to-4 activation mux.
- Fully pipelined valid/ready stream; 1 beat/cycle throughput; saturating statistics counter of pruned non-zero weights.

---
 rtl/sp_weight_compressor_pkg.sv | 48 ++++
 rtl/sp_top2_select.sv | 69 ++++++
 rtl/sp_weight_compressor.sv | 147 ++++++++++++++
 tb/tb_sp_weight_compressor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_weight_compressor_pkg.sv
// Shared constants and helpers for the 2:4 sparse weight path.
// The index-field helpers are also used by the activation-mux select decode.
package sp_weight_compressor_pkg;

    localparam int ELEM_W     = 8;
    localparam int GROUP_SIZE = 4;
    localparam int KEEP       = 2;
    localparam int IDX_W      = 2;

    localparam int MAG_W      = ELEM_W + 1;               // |w| needs 9 bits so |-128| = 128
    localparam int BEAT_ELEMS = 2 * GROUP_SIZE;
    localparam int BEAT_W     = BEAT_ELEMS * ELEM_W;      // dense beat width
    localparam int GRP_W      = GROUP_SIZE * ELEM_W;      // one dense group
    localparam int GMAG_W     = GROUP_SIZE * MAG_W;       // magnitudes of one group
    localparam int WG_W       = 2 * KEEP * ELEM_W;        // compressed beat width
    localparam int IDXB_W     = 2 * KEEP * IDX_W;         // select-index bus width
    localparam int PR_W       = 3;                        // pruned-per-beat count, 0..4

    // Magnitude of a signed element, widened by one bit.
    function automatic logic [MAG_W-1:0] elem_mag(input logic [ELEM_W-1:0] e);
        if (e[ELEM_W-1]) begin
            elem_mag = {1'b0, ~e} + 9'd1;
        end else begin
            elem_mag = {1'b0, e};
        end
    endfunction

    // Pick one element of a dense group by its in-group position.
    function automatic logic [ELEM_W-1:0] pick_elem(input logic [GRP_W-1:0] grp,
                                                   input logic [IDX_W-1:0] pos);
        pick_elem = grp[int'(pos) * ELEM_W +: ELEM_W];
    endfunction

    // Pack four kept-element positions into the select-index bus (k0 in the LSBs).
    function automatic logic [IDXB_W-1:0] idx_pack(input logic [IDX_W-1:0] p0,
                                                  input logic [IDX_W-1:0] p1,
                                                  input logic [IDX_W-1:0] p2,
                                                  input logic [IDX_W-1:0] p3);
        idx_pack = {p3, p2, p1, p0};
    endfunction

    // Extract the position field of kept element j from the select-index bus.
    function automatic logic [IDX_W-1:0] idx_field(input logic [IDXB_W-1:0] idx,
                                                  input logic [1:0]        j);
        idx_field = idx[int'(j) * IDX_W +: IDX_W];
    endfunction

endpackage

// File: rtl/sp_top2_select.sv
// Combinational top-2 picker for one group of four magnitudes.
// An element is outranked by every element with a larger magnitude, and by
// equal-magnitude elements at a lower position; the two least-outranked are kept.
// Zero-magnitude elements fall out naturally: an all-zero group keeps 0,1 and a
// single non-zero element pairs with the lowest-index zero.
module sp_top2_select
    import sp_weight_compressor_pkg::*;
(
    input  logic [GMAG_W-1:0] mag_i,
    output logic [IDX_W-1:0]  pos_lo_o,
    output logic [IDX_W-1:0]  pos_hi_o,
    output logic [PR_W-1:0]   pruned_o
);

    logic [MAG_W-1:0]      mag_s  [GROUP_SIZE];
    logic [2:0]            rank_s [GROUP_SIZE];
    logic [GROUP_SIZE-1:0] keep_s;

    // Unpack the magnitude bus into per-element values.
    always_comb begin
        for (int i = 0; i < GROUP_SIZE; i++) begin
            mag_s[i] = mag_i[i*MAG_W +: MAG_W];
        end
    end

    // Rank each element by how many others beat it, and keep the top KEEP.
    always_comb begin
        for (int i = 0; i < GROUP_SIZE; i++) begin
            rank_s[i] = 3'd0;
            for (int j = 0; j < GROUP_SIZE; j++) begin
                if ((j != i) && ((mag_s[j] > mag_s[i]) || ((mag_s[j] == mag_s[i]) && (j < i)))) begin
                    rank_s[i] = rank_s[i] + 3'd1;
                end else begin
                    rank_s[i] = rank_s[i];
                end
            end
            keep_s[i] = (rank_s[i] < 3'(KEEP));
        end
    end

    // Emit the kept positions in ascending order and count discarded non-zeros.
    always_comb begin
        pos_lo_o = {IDX_W{1'b0}};
        pos_hi_o = {IDX_W{1'b0}};
        pruned_o = {PR_W{1'b0}};
        for (int i = 0; i < GROUP_SIZE; i++) begin
            if (keep_s[i]) begin
                pos_hi_o = IDX_W'(i);
            end else begin
                pos_hi_o = pos_hi_o;
            end
        end
        for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
            if (keep_s[i]) begin
                pos_lo_o = IDX_W'(i);
            end else begin
                pos_lo_o = pos_lo_o;
            end
        end
        for (int i = 0; i < GROUP_SIZE; i++) begin
            if (!keep_s[i] && (mag_s[i] != {MAG_W{1'b0}})) begin
                pruned_o = pruned_o + 3'd1;
            end else begin
                pruned_o = pruned_o;
            end
        end
    end

endmodule

// File: rtl/sp_weight_compressor.sv
// Dense int8 weight rows in, 2:4 structured-sparse weights plus select index out.
// S1 holds the beat and its magnitudes, S2 holds the compressed result and
// drives the outputs directly. A saturating counter tracks pruned non-zeros.
module sp_weight_compressor
    import sp_weight_compressor_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_weights,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WG_W-1:0]   weight_group,
    output logic [IDXB_W-1:0] weight_idx,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  pruned_cnt
);

    localparam int               SUM_W   = CNT_W + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic                          s1_valid_q, s1_valid_d;
    logic [BEAT_W-1:0]             s1_w_q, s1_w_d;
    logic [BEAT_ELEMS*MAG_W-1:0]   s1_mag_q, s1_mag_d, mag_s;
    logic                          s2_valid_q, s2_valid_d;
    logic [WG_W-1:0]               s2_wg_q, s2_wg_d;
    logic [IDXB_W-1:0]             s2_idx_q, s2_idx_d;
    logic [PR_W-1:0]               s2_pr_q, s2_pr_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [SUM_W-1:0]              cnt_sum_s;

    logic                          s1_adv_s, s2_adv_s, out_xfer_s;
    logic [GRP_W-1:0]              grp_a_s, grp_b_s;
    logic [IDX_W-1:0]              a_lo_s, a_hi_s, b_lo_s, b_hi_s;
    logic [PR_W-1:0]               a_pr_s, b_pr_s;

    // Stage advance depends only on stage valids and out_ready, never on in_valid.
    assign s2_adv_s   = !s2_valid_q || out_ready;
    assign s1_adv_s   = !s1_valid_q || s2_adv_s;
    assign out_xfer_s = s2_valid_q && out_ready;
    assign in_ready   = s1_adv_s;

    assign grp_a_s = s1_w_q[GRP_W-1:0];
    assign grp_b_s = s1_w_q[BEAT_W-1:GRP_W];

    sp_top2_select u_sel_a (
        .mag_i    (s1_mag_q[GMAG_W-1:0]),
        .pos_lo_o (a_lo_s),
        .pos_hi_o (a_hi_s),
        .pruned_o (a_pr_s)
    );

    sp_top2_select u_sel_b (
        .mag_i    (s1_mag_q[2*GMAG_W-1:GMAG_W]),
        .pos_lo_o (b_lo_s),
        .pos_hi_o (b_hi_s),
        .pruned_o (b_pr_s)
    );

    // Magnitudes of the incoming beat, captured into S1 alongside the raw weights.
    always_comb begin
        mag_s = {(BEAT_ELEMS*MAG_W){1'b0}};
        for (int i = 0; i < BEAT_ELEMS; i++) begin
            mag_s[i*MAG_W +: MAG_W] = elem_mag(in_weights[i*ELEM_W +: ELEM_W]);
        end
    end

    // Next state of both pipeline stages; S2 data only changes when a real beat moves in.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_w_d     = s1_w_q;
        s1_mag_d   = s1_mag_q;
        s2_valid_d = s2_valid_q;
        s2_wg_d    = s2_wg_q;
        s2_idx_d   = s2_idx_q;
        s2_pr_d    = s2_pr_q;
        if (s1_adv_s) begin
            s1_valid_d = in_valid;
            s1_w_d     = in_weights;
            s1_mag_d   = mag_s;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_wg_d  = {pick_elem(grp_b_s, b_hi_s), pick_elem(grp_b_s, b_lo_s),
                            pick_elem(grp_a_s, a_hi_s), pick_elem(grp_a_s, a_lo_s)};
                s2_idx_d = idx_pack(a_lo_s, a_hi_s, b_lo_s, b_hi_s);
                s2_pr_d  = a_pr_s + b_pr_s;
            end else begin
                s2_pr_d  = s2_pr_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Saturating pruned-non-zero counter; clear wins over a same-cycle increment.
    always_comb begin
        cnt_sum_s = {1'b0, cnt_q} + SUM_W'(s2_pr_q);
        cnt_d     = cnt_q;
        if (clr_cnt) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (out_xfer_s) begin
            if (cnt_sum_s > CNT_MAX) begin
                cnt_d = CNT_MAX[CNT_W-1:0];
            end else begin
                cnt_d = cnt_sum_s[CNT_W-1:0];
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset that drops every in-flight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_w_q     <= {BEAT_W{1'b0}};
            s1_mag_q   <= {(BEAT_ELEMS*MAG_W){1'b0}};
            s2_valid_q <= 1'b0;
            s2_wg_q    <= {WG_W{1'b0}};
            s2_idx_q   <= {IDXB_W{1'b0}};
            s2_pr_q    <= {PR_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_w_q     <= s1_w_d;
            s1_mag_q   <= s1_mag_d;
            s2_valid_q <= s2_valid_d;
            s2_wg_q    <= s2_wg_d;
            s2_idx_q   <= s2_idx_d;
            s2_pr_q    <= s2_pr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign weight_group = s2_wg_q;
    assign weight_idx   = s2_idx_q;
    assign pruned_cnt   = cnt_q;

endmodule

// File: tb/tb_sp_weight_compressor.sv
// Self-checking bench for sp_weight_compressor. Two instances share all inputs:
// a default 16-bit counter build and a 4-bit counter build for saturation.
// Inputs change on the falling edge; outputs are read just after it.
module tb_sp_weight_compressor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        = 1'b1;
    logic        in_valid   = 1'b0;
    logic        out_ready  = 1'b0;
    logic        clr_cnt    = 1'b0;
    logic [63:0] in_weights = 64'h0;

    logic        in_ready, out_valid;
    logic [31:0] weight_group;
    logic [7:0]  weight_idx;
    logic [15:0] pruned_cnt;

    logic        in_ready4, out_valid4;
    logic [31:0] weight_group4;
    logic [7:0]  weight_idx4;
    logic [3:0]  pruned_cnt4;

    typedef struct {
        logic [31:0] wg;
        logic [7:0]  idx;
        int          pr;
    } beat_t;

    beat_t exp_q[$];
    int    exp_cnt  = 0;
    int    exp_cnt4 = 0;
    int    n_cmp    = 0;
    int    n_err    = 0;

    sp_weight_compressor #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_weights(in_weights), .out_valid(out_valid), .out_ready(out_ready),
        .weight_group(weight_group), .weight_idx(weight_idx),
        .clr_cnt(clr_cnt), .pruned_cnt(pruned_cnt)
    );

    sp_weight_compressor #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_weights(in_weights), .out_valid(out_valid4), .out_ready(out_ready),
        .weight_group(weight_group4), .weight_idx(weight_idx4),
        .clr_cnt(clr_cnt), .pruned_cnt(pruned_cnt4)
    );

    // ---------------- reference model ----------------
    function automatic int mag_of(input logic [7:0] e);
        int v;
        v = int'($signed(e));
        return (v < 0) ? -v : v;
    endfunction

    // Pick the largest magnitude (lowest index wins ties), then the next largest.
    function automatic void ref_group(input logic [31:0] g, output logic [15:0] kept,
                                      output logic [3:0] idx, output int pruned);
        int m[4];
        int first, second, lo, hi;
        for (int i = 0; i < 4; i++) m[i] = mag_of(g[8*i +: 8]);
        first = 0;
        for (int i = 1; i < 4; i++) if (m[i] > m[first]) first = i;
        second = -1;
        for (int i = 0; i < 4; i++)
            if (i != first && (second < 0 || m[i] > m[second])) second = i;
        lo = (first < second) ? first : second;
        hi = (first < second) ? second : first;
        kept = {g[8*hi +: 8], g[8*lo +: 8]};
        idx  = {2'(hi), 2'(lo)};
        pruned = 0;
        for (int i = 0; i < 4; i++) if (i != lo && i != hi && m[i] != 0) pruned++;
    endfunction

    function automatic beat_t ref_beat(input logic [63:0] w);
        beat_t b;
        logic [15:0] ka, kb;
        logic [3:0]  ia, ib;
        int          pa, pb;
        ref_group(w[31:0], ka, ia, pa);
        ref_group(w[63:32], kb, ib, pb);
        b.wg  = {kb, ka};
        b.idx = {ib, ia};
        b.pr  = pa + pb;
        return b;
    endfunction

    function automatic logic [63:0] rand_beat();
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0: w[8*i +: 8] = 8'h00;
                1: case ($urandom_range(0, 3))
                       0: w[8*i +: 8] = 8'h80;
                       1: w[8*i +: 8] = 8'h7F;
                       2: w[8*i +: 8] = 8'h04;
                       default: w[8*i +: 8] = 8'hFC;
                   endcase
                default: w[8*i +: 8] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    // One clock: drive inputs at the falling edge, then record what the coming
    // rising edge will transfer and advance the model accordingly.
    task automatic drive_cycle(input logic r, input logic v, input logic [63:0] w,
                               input logic ordy, input logic clr,
                               output logic acc, output logic fire, output logic exp_rdy,
                               output logic have_exp, output beat_t item);
        int occ;
        @(negedge clk);
        rst = r; in_valid = v; in_weights = w; out_ready = ordy; clr_cnt = clr;
        #1;
        occ      = exp_q.size();
        exp_rdy  = !(occ >= 2 && !ordy);
        acc      = !r && in_valid && in_ready;
        fire     = !r && out_valid && out_ready;
        have_exp = 1'b0;
        item     = '{wg: 32'h0, idx: 8'h0, pr: 0};
        if (r) begin
            exp_q.delete();
            exp_cnt  = 0;
            exp_cnt4 = 0;
        end else begin
            if (fire && exp_q.size() > 0) begin
                item     = exp_q.pop_front();
                have_exp = 1'b1;
            end
            if (clr) begin
                exp_cnt  = 0;
                exp_cnt4 = 0;
            end else if (fire && have_exp) begin
                exp_cnt  = (exp_cnt + item.pr > 65535) ? 65535 : exp_cnt + item.pr;
                exp_cnt4 = (exp_cnt4 + item.pr > 15) ? 15 : exp_cnt4 + item.pr;
            end
            if (acc) exp_q.push_back(ref_beat(w));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic a, f, er, he; beat_t it;
        drive_cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, a, f, er, he, it);
        drive_cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, a, f, er, he, it);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (weight_group !== 32'h0) begin n_err++; $display("FAIL reset_weight_group got %h want 0", weight_group); end
        n_cmp++; if (weight_idx !== 8'h0) begin n_err++; $display("FAIL reset_weight_idx got %h want 0", weight_idx); end
        n_cmp++; if (pruned_cnt !== 16'h0) begin n_err++; $display("FAIL reset_pruned_cnt got %0d want 0", pruned_cnt); end
        drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        logic a, f, er, he; beat_t it;
        drive_cycle(1'b0, 1'b1, 64'h7F800000_0003F905, 1'b1, 1'b0, a, f, er, he, it);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL single_accept got %b want 1", a); end
        drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %b want 0", out_valid); end
        drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_latency got %b want 1", out_valid); end
        n_cmp++; if (weight_group !== 32'h7F80F905) begin n_err++; $display("FAIL single_group got %h want 7f80f905", weight_group); end
        n_cmp++; if (weight_idx !== 8'hE4) begin n_err++; $display("FAIL single_idx got %h want e4", weight_idx); end
        drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
        n_cmp++; if (pruned_cnt !== 16'd1) begin n_err++; $display("FAIL single_pruned got %0d want 1", pruned_cnt); end
    endtask

    task automatic test_ties_zeros();
        logic a, f, er, he; beat_t it;
        drive_cycle(1'b0, 1'b1, 64'h09000000_0004FC04, 1'b1, 1'b0, a, f, er, he, it);
        drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
        drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
        n_cmp++; if (f !== 1'b1) begin n_err++; $display("FAIL ties_valid got %b want 1", f); end
        n_cmp++; if (weight_group !== 32'h0900FC04) begin n_err++; $display("FAIL ties_group got %h want 0900fc04", weight_group); end
        n_cmp++; if (weight_idx !== 8'hC4) begin n_err++; $display("FAIL ties_idx got %h want c4", weight_idx); end
        drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
        n_cmp++; if (pruned_cnt !== 16'd2) begin n_err++; $display("FAIL ties_pruned got %0d want 2", pruned_cnt); end
    endtask

    task automatic test_backpressure();
        logic a, f, er, he; beat_t it;
        logic [63:0] cur;
        logic [31:0] prev_wg;
        logic [7:0]  prev_idx;
        logic        stall_prev;
        int          sent, got, cnt_chk;
        sent = 0; got = 0; stall_prev = 1'b0; prev_wg = 32'h0; prev_idx = 8'h0;
        cur = rand_beat();
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            cnt_chk = exp_cnt;
            drive_cycle(1'b0, sent < 16, cur, 1'($urandom_range(0, 1)), 1'b0, a, f, er, he, it);
            n_cmp++; if (in_ready !== er) begin n_err++; $display("FAIL bp_in_ready cyc %0d got %b want %b", cyc, in_ready, er); end
            n_cmp++; if (pruned_cnt !== 16'(cnt_chk)) begin n_err++; $display("FAIL bp_pruned cyc %0d got %0d want %0d", cyc, pruned_cnt, cnt_chk); end
            if (stall_prev) begin
                n_cmp++;
                if (out_valid !== 1'b1 || weight_group !== prev_wg || weight_idx !== prev_idx) begin
                    n_err++;
                    $display("FAIL bp_stall_hold cyc %0d got %b/%h/%h want 1/%h/%h", cyc, out_valid, weight_group, weight_idx, prev_wg, prev_idx);
                end
            end
            if (f) begin
                n_cmp++; if (he !== 1'b1) begin n_err++; $display("FAIL bp_duplicate cyc %0d got extra beat %h", cyc, weight_group); end
                n_cmp++; if (weight_group !== it.wg || weight_idx !== it.idx) begin
                    n_err++; $display("FAIL bp_data beat %0d got %h/%h want %h/%h", got, weight_group, weight_idx, it.wg, it.idx);
                end
                got++;
            end
            if (a) begin sent++; cur = rand_beat(); end
            stall_prev = out_valid && !out_ready;
            prev_wg = weight_group; prev_idx = weight_idx;
        end
        n_cmp++; if (got !== 16) begin n_err++; $display("FAIL bp_count got %0d beats want 16", got); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL bp_leftover got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic a, f, er, he; beat_t it;
        int first, nfire;
        first = -1; nfire = 0;
        for (int i = 0; i < 36; i++) begin
            drive_cycle(1'b0, i < 32, rand_beat(), 1'b1, 1'b0, a, f, er, he, it);
            if (i < 32) begin
                n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL b2b_accept cyc %0d got %b want 1", i, a); end
            end
            n_cmp++; if (f !== (i >= 2 && i < 34)) begin n_err++; $display("FAIL b2b_valid cyc %0d got %b want %b", i, f, (i >= 2 && i < 34)); end
            if (f) begin
                if (first < 0) first = i;
                nfire++;
                n_cmp++; if (!he || weight_group !== it.wg || weight_idx !== it.idx) begin
                    n_err++; $display("FAIL b2b_data cyc %0d got %h/%h want %h/%h", i, weight_group, weight_idx, it.wg, it.idx);
                end
            end
        end
        n_cmp++; if (nfire !== 32) begin n_err++; $display("FAIL b2b_count got %0d want 32", nfire); end
        n_cmp++; if (first !== 2) begin n_err++; $display("FAIL b2b_first got %0d want 2", first); end
    endtask

    task automatic test_counter();
        logic a, f, er, he; beat_t it;
        int c4, c16;
        drive_cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, a, f, er, he, it);
        for (int i = 0; i < 12; i++) begin
            c4 = exp_cnt4; c16 = exp_cnt;
            drive_cycle(1'b0, i < 10, 64'h00000000_04030201, 1'b1, 1'b0, a, f, er, he, it);
            n_cmp++; if (pruned_cnt4 !== 4'(c4)) begin n_err++; $display("FAIL cnt4_step %0d got %0d want %0d", i, pruned_cnt4, c4); end
            n_cmp++; if (pruned_cnt !== 16'(c16)) begin n_err++; $display("FAIL cnt16_step %0d got %0d want %0d", i, pruned_cnt, c16); end
        end
        drive_cycle(1'b0, 1'b1, 64'h00000000_04030201, 1'b0, 1'b0, a, f, er, he, it);
        n_cmp++; if (pruned_cnt4 !== 4'd15) begin n_err++; $display("FAIL cnt4_saturate got %0d want 15", pruned_cnt4); end
        n_cmp++; if (pruned_cnt !== 16'd20) begin n_err++; $display("FAIL cnt16_total got %0d want 20", pruned_cnt); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, a, f, er, he, it);
            n_cmp++; if (pruned_cnt !== 16'd20) begin n_err++; $display("FAIL cnt_stall %0d got %0d want 20", i, pruned_cnt); end
        end
        drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, a, f, er, he, it);
        n_cmp++; if (f !== 1'b1) begin n_err++; $display("FAIL cnt_clr_xfer got %b want 1", f); end
        drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
        n_cmp++; if (pruned_cnt !== 16'd0 || pruned_cnt4 !== 4'd0) begin
            n_err++; $display("FAIL cnt_clr got %0d/%0d want 0/0", pruned_cnt, pruned_cnt4);
        end
    endtask

    task automatic test_reset_midstream();
        logic a, f, er, he; beat_t it;
        drive_cycle(1'b0, 1'b1, 64'h00000000_04030201, 1'b1, 1'b0, a, f, er, he, it);
        drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
        drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
        drive_cycle(1'b0, 1'b1, 64'h11223344_55667788, 1'b0, 1'b0, a, f, er, he, it);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL mid_accept0 got %b want 1", a); end
        drive_cycle(1'b0, 1'b1, 64'h01000000_00000300, 1'b0, 1'b0, a, f, er, he, it);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL mid_accept1 got %b want 1", a); end
        n_cmp++; if (pruned_cnt !== 16'd2) begin n_err++; $display("FAIL mid_pre_cnt got %0d want 2", pruned_cnt); end
        drive_cycle(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, a, f, er, he, it);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_ghost cyc %0d got %b want 0", i, out_valid); end
            n_cmp++; if (pruned_cnt !== 16'd0) begin n_err++; $display("FAIL mid_cnt cyc %0d got %0d want 0", i, pruned_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ties_zeros();
        test_backpressure();
        test_back_to_back();
        test_counter();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
